// File: rtl/ahb_pkg.sv
// AHB slave shared types: transfer/size/response encodings, slave FSM state, byte-lane helper.
// Latency: none (types and a pure function).
// Backpressure: not applicable.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } slv_state_t;

  // Little-endian byte enables for an aligned transfer of 2**sz bytes at offset a.
  function automatic logic [3:0] lane_en(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    lane_en = 4'b0001 << a;
      2'd1:    lane_en = 4'b0011 << a;
      default: lane_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slv_if.sv
// AHB-lite bus bundle between one master-side driver and the SRAM slave.
// Latency: none (wiring only).
// Backpressure: slave stalls the data phase through hreadyout; address phase qualified by hready.
interface ahb_sram_slv_if #(
  parameter int ADDRW = 32,
  parameter int DATAW = 32
);
  logic             hsel;
  logic [ADDRW-1:0] haddr;
  logic [1:0]       htrans;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [2:0]       hburst;
  logic [DATAW-1:0] hwdata;
  logic             hready;
  logic             hreadyout;
  logic             hresp;
  logic [DATAW-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM array with per-byte write enables and an asynchronous read port.
// Latency: write lands at the clock edge; read is combinational from raddr.
// Backpressure: none; always accepts a write.
module ahb_sram_mem #(
  parameter int IDXW  = 8,
  parameter int DATAW = 32
) (
  input  logic               clk,
  input  logic [DATAW/8-1:0] be,
  input  logic [IDXW-1:0]    waddr,
  input  logic [DATAW-1:0]   wdata,
  input  logic [IDXW-1:0]    raddr,
  output logic [DATAW-1:0]   rdata
);
  logic [DATAW-1:0] mem [0:(1<<IDXW)-1];

  // Byte-lane write; lanes with be=0 keep their contents. No reset on the array.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATAW/8; i++) begin
      if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/ahb_sram_slv.sv
// AHB-lite SRAM slave: registers the address phase, checks range/alignment, commits writes byte-wise.
// Latency: WAIT_STATES stall cycles per OKAY data phase; ERROR takes two cycles (stall, then complete).
// Backpressure: hreadyout=0 stretches the data phase; address phases only accepted when hready=1.
module ahb_sram_slv
  import ahb_pkg::*;
#(
  parameter int ADDRW       = 32,
  parameter int DATAW       = 32,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic           clk,
  input logic           rst,
  ahb_sram_slv_if.slave bus
);
  localparam int         IDXW    = $clog2(MEM_BYTES) - 2;
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

  slv_state_t       state;
  logic [3:0]       cnt;
  logic [ADDRW-1:0] addr_q;
  logic             write_q;
  logic [1:0]       size_q;
  logic             dph_q;       // a legal transfer owns the current data phase
  logic             hreadyout_q;
  hresp_t           hresp_q;

  logic             accept;
  logic             legal;
  logic             we;
  logic [3:0]       be;
  logic [DATAW-1:0] rd_word;
  logic             unused_ok;

  assign accept = bus.hsel && bus.hready &&
                  (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);

  assign legal = (bus.haddr < ADDRW'(MEM_BYTES)) &&
                 (bus.hsize <= HSIZE_WORD) &&
                 !(bus.hsize == HSIZE_HALF && bus.haddr[0]) &&
                 !(bus.hsize == HSIZE_WORD && bus.haddr[1:0] != 2'b00);

  // Commit only in the completing OKAY cycle; reset clears dph_q so an aborted write never lands.
  assign we = dph_q && write_q && hreadyout_q && (hresp_q == HRESP_OKAY);
  assign be = we ? lane_en(addr_q[1:0], size_q) : 4'b0000;

  ahb_sram_mem #(
    .IDXW  (IDXW),
    .DATAW (DATAW)
  ) u_mem (
    .clk   (clk),
    .be    (be),
    .waddr (addr_q[IDXW+1:2]),
    .wdata (bus.hwdata),
    .raddr (addr_q[IDXW+1:2]),
    .rdata (rd_word)
  );

  // Slave FSM: accepts in ST_IDLE/ST_ERR2 (completing cycles), stalls in ST_WAIT, two-cycle error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      dph_q       <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == WS_LAST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            hreadyout_q <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
        end
        ST_IDLE, ST_ERR2: begin
          state       <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
          dph_q       <= 1'b0;
          if (accept) begin
            addr_q  <= bus.haddr;
            write_q <= bus.hwrite;
            size_q  <= bus.hsize[1:0];
            if (!legal) begin
              state       <= ST_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else begin
              dph_q <= 1'b1;
              if (WAIT_STATES > 0) begin
                state       <= ST_WAIT;
                cnt         <= '0;
                hreadyout_q <= 1'b0;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = (dph_q && !write_q && hreadyout_q && hresp_q == HRESP_OKAY) ? rd_word : '0;

  // Burst type and address bits above the array index play no part in the access.
  assign unused_ok = ^{bus.hburst, addr_q[ADDRW-1:IDXW+2]};
endmodule

// File: tb/tb_ahb_sram_slv.sv
// Bench: two SRAM slaves (0 and 1 wait states) plus a phantom slave on one AHB-lite bus.
// Latency: driver pipelines address/data phases; monitor checks each completed data phase.
// Backpressure: hready follows the data-phase owner; the phantom slave stalls randomly.
module tb_ahb_sram_slv;
  import ahb_pkg::*;

  localparam int WS0 = 0;
  localparam int WS1 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahb_sram_slv_if #(.ADDRW(32), .DATAW(32)) bus0 ();
  ahb_sram_slv_if #(.ADDRW(32), .DATAW(32)) bus1 ();

  logic        m_hsel0, m_hsel1, m_hwrite;
  logic [31:0] m_haddr, m_hwdata;
  logic [1:0]  m_htrans;
  logic [2:0]  m_hsize, m_hburst;
  int          dp_owner;
  logic        phantom_rdy;
  logic        hready_bus;

  assign bus0.hsel = m_hsel0;   assign bus1.hsel = m_hsel1;
  assign bus0.haddr = m_haddr;  assign bus1.haddr = m_haddr;
  assign bus0.htrans = m_htrans; assign bus1.htrans = m_htrans;
  assign bus0.hwrite = m_hwrite; assign bus1.hwrite = m_hwrite;
  assign bus0.hsize = m_hsize;  assign bus1.hsize = m_hsize;
  assign bus0.hburst = m_hburst; assign bus1.hburst = m_hburst;
  assign bus0.hwdata = m_hwdata; assign bus1.hwdata = m_hwdata;
  assign hready_bus = (dp_owner == 0) ? bus0.hreadyout :
                      (dp_owner == 1) ? bus1.hreadyout : phantom_rdy;
  assign bus0.hready = hready_bus;
  assign bus1.hready = hready_bus;

  ahb_sram_slv #(.ADDRW(32), .DATAW(32), .MEM_BYTES(1024), .WAIT_STATES(WS0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0));
  ahb_sram_slv #(.ADDRW(32), .DATAW(32), .MEM_BYTES(1024), .WAIT_STATES(WS1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1));

  typedef struct { int tgt; logic [1:0] trans; logic wr; logic [31:0] addr; logic [2:0] size; logic [31:0] wdata; } item_t;
  typedef struct { int tgt; int waits; logic resp; logic chk; logic [31:0] data; logic [31:0] mask; } exp_t;

  item_t      stim_q[$];
  exp_t       exp_q[$];
  logic [7:0] mdat   [2][1024];
  bit         mknown [2][1024];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         mon_en  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Queue a transfer and predict its response from a byte-addressed model of each slave.
  function automatic void add(input int tgt, input logic [1:0] tr, input logic wr,
                              input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    item_t it;
    exp_t  e;
    int    ad;
    int    nb;
    it.tgt = tgt; it.trans = tr; it.wr = wr; it.addr = a; it.size = sz; it.wdata = wd;
    stim_q.push_back(it);
    if (tgt > 1 || tr[1] == 1'b0) return;
    e.tgt = tgt; e.chk = 1'b0; e.data = '0; e.mask = '0;
    if (a >= 32'd1024 || sz > 3'd2 || (a % (32'd1 << sz)) != 0) begin
      e.resp = 1'b1; e.waits = 1;
    end else begin
      e.resp  = 1'b0;
      e.waits = (tgt == 1) ? WS1 : WS0;
      nb = 1 << sz;
      if (wr) begin
        for (int b = 0; b < nb; b++) begin
          ad = int'(a) + b;
          mdat[tgt][ad]   = wd[8*(ad%4) +: 8];
          mknown[tgt][ad] = 1'b1;
        end
      end else begin
        e.chk = 1'b1;
        for (int b = 0; b < 4; b++) begin
          ad = (int'(a) & ~3) + b;
          if (mknown[tgt][ad]) begin
            e.data[8*b +: 8] = mdat[tgt][ad];
            e.mask[8*b +: 8] = 8'hFF;
          end
        end
      end
    end
    exp_q.push_back(e);
  endfunction

  task automatic idle_addr();
    m_hsel0 = 1'b0; m_hsel1 = 1'b0; m_htrans = HTRANS_IDLE; m_haddr = '0;
    m_hwrite = 1'b0; m_hsize = 3'd0; m_hburst = 3'd0;
  endtask

  // Pipelined AHB master: address phase of the next item overlaps the current data phase.
  task automatic run_bus();
    item_t ap, dp;
    bit    ap_v, dp_v, rdy;
    int    cyc;
    ap_v = 0; dp_v = 0; cyc = 0;
    while (ap_v || dp_v || stim_q.size() > 0) begin
      if (!ap_v && stim_q.size() > 0) begin ap = stim_q.pop_front(); ap_v = 1; end
      if (ap_v) begin
        m_hsel0 = (ap.tgt == 0); m_hsel1 = (ap.tgt == 1);
        m_htrans = ap.trans; m_haddr = ap.addr; m_hwrite = ap.wr; m_hsize = ap.size;
        m_hburst = 3'($urandom_range(0, 7));
      end else begin
        idle_addr();
      end
      dp_owner    = dp_v ? dp.tgt : 3;
      phantom_rdy = (dp_v && dp.tgt == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      m_hwdata    = dp_v ? dp.wdata : 32'h0;
      @(negedge clk);
      rdy = hready_bus;
      @(posedge clk);
      #1;
      if (rdy) begin
        dp_v = 0;
        if (ap_v) begin
          if (ap.trans[1]) begin dp = ap; dp_v = 1; end
          ap_v = 0;
        end
      end
      cyc++;
      if (cyc > 4000) begin
        n_tests++; n_fail++;
        $display("FAIL bus_timeout: %0d cycles elapsed, %0d items not issued", cyc, stim_q.size());
        stim_q.delete(); ap_v = 0; dp_v = 0;
      end
    end
    idle_addr(); dp_owner = 3; phantom_rdy = 1'b1; m_hwdata = '0;
  endtask

  // Monitor: follows data-phase ownership from bus signals and scores each completion.
  initial begin : monitor
    int          owner, cur, waits;
    logic        wresp, rdy_o, rsp_o;
    logic [31:0] rd_o;
    exp_t        e;
    owner = -1; waits = 0; wresp = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        owner = -1; waits = 0; wresp = 1'b0;
      end else begin
        cur = owner;
        if (owner >= 0) begin
          rdy_o = (owner == 0) ? bus0.hreadyout : bus1.hreadyout;
          rsp_o = (owner == 0) ? bus0.hresp     : bus1.hresp;
          rd_o  = (owner == 0) ? bus0.hrdata    : bus1.hrdata;
          if (!rdy_o) begin
            waits++;
            wresp |= rsp_o;
          end else begin
            if (exp_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL sb_unexpected: slave %0d completed a data phase, none expected", owner);
            end else begin
              e = exp_q.pop_front();
              check("sb_target", 32'(owner), 32'(e.tgt));
              check("sb_waits", 32'(waits), 32'(e.waits));
              check("sb_resp", 32'(rsp_o), 32'(e.resp));
              if (waits > 0) check("sb_wait_resp", 32'(wresp), 32'(e.resp));
              if (e.chk) check("sb_rdata", rd_o & e.mask, e.data);
            end
            owner = -1;
          end
        end
        if (cur != 0) begin
          check("idle0_hreadyout", 32'(bus0.hreadyout), 32'd1);
          check("idle0_hresp", 32'(bus0.hresp), 32'd0);
          check("idle0_hrdata", bus0.hrdata, 32'd0);
        end
        if (cur != 1) begin
          check("idle1_hreadyout", 32'(bus1.hreadyout), 32'd1);
          check("idle1_hresp", 32'(bus1.hresp), 32'd0);
          check("idle1_hrdata", bus1.hrdata, 32'd0);
        end
        if (hready_bus) begin
          if (bus0.hsel && bus0.htrans[1])      owner = 0;
          else if (bus1.hsel && bus1.htrans[1]) owner = 1;
          else                                  owner = -1;
          waits = 0; wresp = 1'b0;
        end
      end
    end
  end

  initial begin : main
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] a;
    int          tg;
    rst = 1'b0;
    idle_addr(); dp_owner = 3; phantom_rdy = 1'b1; m_hwdata = '0;
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 1024; i++) begin mknown[t][i] = 1'b0; mdat[t][i] = 8'h00; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst0_hreadyout", 32'(bus0.hreadyout), 32'd1);
    check("rst0_hresp", 32'(bus0.hresp), 32'd0);
    check("rst0_hrdata", bus0.hrdata, 32'd0);
    check("rst1_hreadyout", 32'(bus1.hreadyout), 32'd1);
    check("rst1_hresp", 32'(bus1.hresp), 32'd0);
    check("rst1_hrdata", bus1.hrdata, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 mon_en = 1;

    // Directed cases on the 1-wait slave.
    add(1, HTRANS_NONSEQ, 1'b1, 32'h010, 3'd2, 32'hDEADBEEF);
    add(1, HTRANS_NONSEQ, 1'b0, 32'h010, 3'd2, 32'h0);
    add(1, HTRANS_NONSEQ, 1'b1, 32'h030, 3'd2, 32'h0BADC0DE);
    add(1, HTRANS_NONSEQ, 1'b1, 32'h010, 3'd2, 32'h11223344);
    add(1, HTRANS_NONSEQ, 1'b1, 32'h013, 3'd0, {8'hAA, 24'h5A5A5A});
    add(1, HTRANS_NONSEQ, 1'b0, 32'h010, 3'd2, 32'h0);
    add(1, HTRANS_NONSEQ, 1'b0, 32'h400, 3'd2, 32'h0);
    add(1, HTRANS_NONSEQ, 1'b0, 32'h010, 3'd2, 32'h0);
    add(1, HTRANS_NONSEQ, 1'b1, 32'h011, 3'd1, 32'hFFFFFFFF);
    add(1, HTRANS_NONSEQ, 1'b0, 32'h010, 3'd2, 32'h0);
    add(1, HTRANS_NONSEQ, 1'b1, 32'h012, 3'd2, 32'hFFFFFFFF);
    add(1, HTRANS_NONSEQ, 1'b1, 32'h010, 3'd3, 32'hFFFFFFFF);
    add(1, HTRANS_BUSY,   1'b1, 32'h010, 3'd2, 32'h0);
    add(1, HTRANS_IDLE,   1'b1, 32'h010, 3'd2, 32'h0);
    add(1, HTRANS_NONSEQ, 1'b0, 32'h010, 3'd2, 32'h0);
    // Zero-wait slave: burst to 0x20..0x2C behind a randomly stalling phantom slave.
    add(2, HTRANS_NONSEQ, 1'b0, 32'h100, 3'd2, 32'h0);
    add(2, HTRANS_SEQ,    1'b0, 32'h104, 3'd2, 32'h0);
    for (int k = 0; k < 4; k++)
      add(0, (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, 32'h020 + 32'(4*k), 3'd2, $urandom);
    add(2, HTRANS_NONSEQ, 1'b1, 32'h200, 3'd2, 32'h0);
    for (int k = 0; k < 4; k++)
      add(0, HTRANS_NONSEQ, 1'b0, 32'h020 + 32'(4*k), 3'd2, 32'h0);
    run_bus();

    // Randomised mix across both slaves and the phantom.
    for (int n = 0; n < 150; n++) begin
      tg = $urandom_range(0, 2);
      sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 3'd1) a[0] = 1'b0;
        if (sz == 3'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 11) == 0) a = 32'h400 + 32'($urandom_range(0, 4095));
      tr = ($urandom_range(0, 7) == 0) ? 2'd1 : (($urandom_range(0, 1) == 0) ? 2'd2 : 2'd3);
      add(tg, tr, 1'($urandom_range(0, 1)), a, sz, $urandom);
    end
    for (int k = 0; k < 16; k++) add(k % 2, HTRANS_NONSEQ, 1'b0, 32'(4*k), 3'd2, 32'h0);
    run_bus();

    // Reset asserted while the 1-wait slave is stalling a write to 0x030.
    mon_en = 0;
    m_hsel0 = 1'b0; m_hsel1 = 1'b1; m_htrans = HTRANS_NONSEQ; m_haddr = 32'h030;
    m_hwrite = 1'b1; m_hsize = 3'd2; dp_owner = 3;
    @(posedge clk);
    #1;
    idle_addr(); dp_owner = 1; m_hwdata = 32'hCAFEF00D;
    check("rst_mid_wait_hreadyout", 32'(bus1.hreadyout), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_hreadyout", 32'(bus1.hreadyout), 32'd1);
    check("rst_mid_hresp", 32'(bus1.hresp), 32'd0);
    check("rst_mid_hrdata", bus1.hrdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; dp_owner = 3; m_hwdata = '0;
    @(posedge clk);
    #1 mon_en = 1;
    add(1, HTRANS_NONSEQ, 1'b0, 32'h030, 3'd2, 32'h0);
    run_bus();

    repeat (3) @(posedge clk);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
